// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, decryptor FSM states, inverse S-box and GF(2^8) helpers.
package aes_pkg;

   localparam int NR = 10;

   typedef enum logic [1:0] {IDLE, LOAD, DEC, FIN} state_t;

   // Entry i is InvSubBytes(i); row-major, element 0 first.
   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm9(input logic [7:0] b);
      return xt(xt(xt(b))) ^ b;
   endfunction

   function automatic logic [7:0] gmb(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(b) ^ b;
   endfunction

   function automatic logic [7:0] gmd(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
   endfunction

   function automatic logic [7:0] gme(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
   endfunction

   // One column of InvMixColumns; byte 0 of the column sits in bits [31:24].
   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {gme(a0) ^ gmb(a1) ^ gmd(a2) ^ gm9(a3),
              gm9(a0) ^ gme(a1) ^ gmb(a2) ^ gmd(a3),
              gmd(a0) ^ gm9(a1) ^ gme(a2) ^ gmb(a3),
              gmb(a0) ^ gmd(a1) ^ gm9(a2) ^ gme(a3)};
   endfunction

endpackage

// File: rtl/inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless bypassed.
module inv_round
   import aes_pkg::*;
(
   input  logic [127:0] st,
   input  logic [127:0] rk,
   input  logic         bypass,
   output logic [127:0] res
);

   logic [15:0][7:0] sb;
   logic [127:0]     ak;
   logic [127:0]     mx;

   // Byte r+4c takes row r from column (c-r) mod 4, i.e. each row rotates right by r.
   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < 4; c++) begin : g_col
         assign sb[15-(r+4*c)] = INV_SBOX[st[127-8*(r+4*((c+4-r)%4)) -: 8]];
      end
   end

   assign ak = sb ^ rk;

   for (genvar c = 0; c < 4; c++) begin : g_mix
      assign mx[127-32*c -: 32] = inv_mix_col(ak[127-32*c -: 32]);
   end

   assign res = bypass ? ak : mx;

endmodule

// File: rtl/inv_cipher.sv
// Iterative AES-128 decryptor: buffers NR+1 forward-order round keys, then runs one inverse round per cycle.
module inv_cipher #(
   parameter int NR = aes_pkg::NR
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         keyValid,
   input  logic [127:0] wBlock,
   input  logic [127:0] in,
   output logic [127:0] out,
   output logic         done
);
   import aes_pkg::*;

   localparam logic [3:0] NR4 = 4'(NR);

   state_t       state, nxt;
   logic [127:0] stm;
   logic [127:0] keyMem [0:NR];
   logic [3:0]   kcnt, rcnt;
   logic [127:0] rnd_out;
   logic         load_in, kwr, dec_en;

   inv_round u_round (
      .st     (stm),
      .rk     (keyMem[rcnt]),
      .bypass (rcnt == 4'd0),
      .res    (rnd_out)
   );

   always_comb begin
      nxt     = state;
      load_in = 1'b0;
      kwr     = 1'b0;
      dec_en  = 1'b0;
      case (state)
         IDLE, FIN: begin
            if (start) begin
               load_in = 1'b1;
               nxt     = LOAD;
            end
         end
         LOAD: begin
            if (keyValid) begin
               kwr = 1'b1;
               if (kcnt == NR4) nxt = DEC;
            end
         end
         DEC: begin
            dec_en = 1'b1;
            if (rcnt == 4'd0) nxt = FIN;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         stm   <= '0;
         kcnt  <= '0;
         rcnt  <= '0;
      end else begin
         state <= nxt;
         if (load_in) begin
            stm  <= in;
            kcnt <= '0;
         end
         if (kwr) begin
            kcnt <= kcnt + 4'd1;
            if (kcnt == NR4) rcnt <= NR4;
         end
         if (dec_en) begin
            // First DEC cycle is the lone AddRoundKey with the last round key.
            stm <= (rcnt == NR4) ? (stm ^ keyMem[NR]) : rnd_out;
            if (rcnt != 4'd0) rcnt <= rcnt - 4'd1;
         end
      end
   end

   // Key buffer is fully rewritten on every LOAD pass, so it needs no reset.
   always_ff @(posedge clk) begin
      if (!reset && kwr) keyMem[kcnt] <= wBlock;
   end

   assign done = (state == FIN);
   assign out  = done ? stm : '0;

endmodule

// File: tb/tb_inv_cipher.sv
// Directed bench for inv_cipher using FIPS-197 vectors; round keys come from a local key expansion.
module tb_inv_cipher;

   logic         clk;
   logic         reset;
   logic         start;
   logic         keyValid;
   logic [127:0] wBlock;
   logic [127:0] in;
   logic [127:0] out;
   logic         done;

   int nchk  = 0;
   int nfail = 0;

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

   inv_cipher #(.NR(10)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .keyValid (keyValid),
      .wBlock   (wBlock),
      .in       (in),
      .out      (out),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // AES-128 forward key schedule; returns round key r.
   function automatic logic [127:0] rkey(input logic [127:0] key, input int r);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]} ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ t;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock, sample 1 time unit later, and check out is blank while done is low.
   task automatic step();
      @(posedge clk);
      #1;
      if (done !== 1'b1) chk("out_zero_when_not_done", out, 128'h0);
   endtask

   task automatic run(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] pt,
                      input bit alt, input bit disturb, input string tag);
      in       = ct;
      start    = 1'b1;
      keyValid = 1'b1;
      wBlock   = {$urandom, $urandom, $urandom, $urandom};
      step();
      start    = 1'b0;
      keyValid = 1'b0;
      chk({tag, "_done_drop"}, {127'h0, done}, 128'h0);
      for (int k = 0; k <= 10; k++) begin
         if (alt) begin
            keyValid = 1'b0;
            wBlock   = {$urandom, $urandom, $urandom, $urandom};
            step();
         end
         keyValid = 1'b1;
         wBlock   = rkey(key, k);
         if (disturb) begin
            start = 1'b1;
            in    = ~ct;
         end
         step();
         keyValid = 1'b0;
         start    = 1'b0;
      end
      for (int d = 0; d < 10; d++) begin
         if (disturb) begin
            start    = 1'b1;
            in       = ct ^ 128'h1;
            keyValid = 1'b1;
         end
         step();
      end
      start    = 1'b0;
      keyValid = 1'b0;
      chk({tag, "_done_early"}, {127'h0, done}, 128'h0);
      step();
      chk({tag, "_done"}, {127'h0, done}, 128'h1);
      chk({tag, "_out"}, out, pt);
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b1;
      keyValid = 1'b1;
      wBlock   = '1;
      in       = C1_CT;
      step();
      step();
      chk("reset_done", {127'h0, done}, 128'h0);
      chk("reset_out", out, 128'h0);

      // Stray keys in IDLE must not advance anything.
      reset = 1'b0;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wBlock = {$urandom, $urandom, $urandom, $urandom};
         step();
      end
      keyValid = 1'b0;
      chk("idle_done", {127'h0, done}, 128'h0);

      run(C1_KEY, C1_CT, C1_PT, 1'b0, 1'b0, "c1");

      // FIN holds its result and ignores keyValid.
      keyValid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wBlock = {$urandom, $urandom, $urandom, $urandom};
         step();
      end
      keyValid = 1'b0;
      chk("fin_hold_done", {127'h0, done}, 128'h1);
      chk("fin_hold_out", out, C1_PT);

      run(B_KEY, B_CT, B_PT, 1'b1, 1'b0, "appb");
      run(C1_KEY, C1_CT, C1_PT, 1'b0, 1'b1, "c1_disturb");

      // Reset while the DEC round counter sits at 5.
      in    = C1_CT;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k <= 10; k++) begin
         keyValid = 1'b1;
         wBlock   = rkey(C1_KEY, k);
         step();
      end
      keyValid = 1'b0;
      for (int d = 0; d < 5; d++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_done", {127'h0, done}, 128'h0);
      chk("mid_rst_out", out, 128'h0);
      for (int i = 0; i < 12; i++) step();
      chk("mid_rst_stays_idle", {127'h0, done}, 128'h0);

      run(C1_KEY, C1_CT, C1_PT, 1'b0, 1'b0, "c1_after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
      $finish;
   end

endmodule

// File: doc/inv_cipher.md
INV_CIPHER -- requirements
Module: inv_cipher

Interface
REQ-001 SHALL have parameter NR, default 10: number of AES-128 rounds; the key buffer holds NR+1 round-key blocks.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: begin a decryption; in is sampled in the same cycle.
REQ-005 SHALL have port keyValid, input, 1 bit: wBlock carries the next round-key block this cycle.
REQ-006 SHALL have port wBlock, input, 128 bits: round-key block from key expansion, presented in forward order (round 0 first).
REQ-007 SHALL have port in, input, 128 bits: ciphertext block; byte 0 is in[127:120]; state bytes are column-major.
REQ-008 SHALL have port out, output, 128 bits: plaintext block, same byte order as in.
REQ-009 SHALL have port done, output, 1 bit: high while a valid plaintext is on out.

Function
REQ-010 SHALL implement a four-state FSM with states IDLE, LOAD, DEC and FIN.
REQ-011 IDLE: start=1 SHALL load the state register stm with in, clear the key counter kcnt to 0, and go to LOAD.
REQ-012 LOAD: each cycle with keyValid=1 SHALL write wBlock into keyMem[kcnt] and increment kcnt.
REQ-013 LOAD: keyValid=0 SHALL stall, with no write and no state change.
REQ-014 LOAD: the write with kcnt==NR SHALL move the FSM to DEC and set rcnt to NR.
REQ-015 DEC, rcnt==NR: SHALL compute stm <= stm ^ keyMem[NR].
REQ-016 DEC, rcnt in NR-1..1: SHALL compute stm <= InvMixColumns(InvSubBytes(InvShiftRows(stm)) ^ keyMem[rcnt]).
REQ-017 DEC, rcnt==0: SHALL compute stm <= InvSubBytes(InvShiftRows(stm)) ^ keyMem[0], then go to FIN.
REQ-018 DEC: SHALL decrement rcnt by 1 every cycle, so DEC lasts exactly NR+1 cycles.
REQ-019 FIN: SHALL drive out=stm and done=1, and hold them until start or reset.
REQ-020 FIN: start=1 SHALL behave as in IDLE (capture in, go to LOAD); done SHALL drop the next cycle.
REQ-021 In IDLE, LOAD and DEC, out SHALL be 0 and done SHALL be 0; intermediate state is never exposed.
REQ-022 Latency: start at cycle T with keys on T+1..T+NR+1 back-to-back SHALL give done=1 at cycle T+2*NR+3.
REQ-023 start asserted in LOAD or DEC SHALL be ignored.
REQ-024 keyValid asserted in IDLE, DEC or FIN SHALL be ignored.
REQ-025 start and keyValid asserted together in IDLE or FIN: start SHALL take effect and keyValid SHALL be ignored that cycle.
REQ-026 kcnt SHALL be 4 bits wide and rcnt SHALL be 4 bits wide; neither SHALL wrap, because of the transitions in REQ-014 and REQ-017.

Reset
REQ-027 reset=1 SHALL, at the next edge and in any state, force IDLE, stm=0, kcnt=0 and rcnt=0, so out=0 and done=0.
REQ-028 keyMem SHALL NOT be reset; it is always fully rewritten before use.
REQ-029 reset SHALL take priority over start and keyValid in the same cycle.

Structure
REQ-030 The state enum and NR SHALL live in shared package aes_pkg.
REQ-031 The inverse S-box table SHALL live in aes_pkg.
REQ-032 A combinational sub-module inv_round SHALL implement InvShiftRows, InvSubBytes and InvMixColumns, with a bypass input for the final round.
REQ-033 keyMem SHALL be an (NR+1) x 128 register array with no RAM macro.

Verification
REQ-034 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, in=69c4e0d86a7b0430d8cdb78070b4c55a, keys back-to-back -> out=00112233445566778899aabbccddeeff, done at T+23.
REQ-035 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, in=3925841d02dc09fbdc118597196a0b32, keyValid low on alternate cycles -> out=3243f6a8885a308d313198a2e0370734, done at T+34.
REQ-036 reset pulsed in DEC at rcnt=5 -> out=0 and done=0 next cycle; a following C.1 run -> correct plaintext.
REQ-037 start pulsed with a different in during LOAD and DEC -> ignored, C.1 plaintext unchanged.
REQ-038 In FIN, start with the App. B ciphertext and App. B keys -> done drops next cycle, then the App. B plaintext appears.
REQ-039 Throughout every scenario, out SHALL be 0 whenever done=0.
